// File: rtl/pipe_stall_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_pkg
// Description : Shared types and parameter legality check for the pipeline
//               stall/flush sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

   // Sequencer states: normal flow, mul/div in flight, watchdog lockout.
   typedef enum logic [1:0] {
      RUN     = 2'd0,
      MD_EXEC = 2'd1,
      ERR     = 2'd2
   } state_t;

   // The watchdog must outlast a complete mul/div freeze, otherwise a
   // legitimate long operation would trip it.
   function automatic bit params_ok(input int md_latency,
                                    input int wdog_limit,
                                    input int cnt_w);
      return (md_latency >= 2) && (wdog_limit > md_latency + 1) && (cnt_w >= 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_stall_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stall_ctrl_if
// Description : Request/control bundle between the pipeline and the stall
//               sequencer. master = pipeline side, slave = sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_stall_ctrl_if #(
   parameter int CNT_W = 16
);
   logic             hazard_stall;
   logic             branch_flush;
   logic             md_start;
   logic             dmem_wait;
   logic             imem_wait;
   logic             pc_we;
   logic             ifid_we;
   logic             idex_we;
   logic             exmem_we;
   logic             ifid_flush;
   logic             idex_bubble;
   logic             exmem_bubble;
   logic             memwb_bubble;
   logic             md_go;
   logic             md_busy;
   logic             md_result_valid;
   logic             wdog_err;
   logic [CNT_W-1:0] stall_cycles;
   logic [CNT_W-1:0] flush_count;

   modport master (
      output hazard_stall, branch_flush, md_start, dmem_wait, imem_wait,
      input  pc_we, ifid_we, idex_we, exmem_we,
      input  ifid_flush, idex_bubble, exmem_bubble, memwb_bubble,
      input  md_go, md_busy, md_result_valid, wdog_err,
      input  stall_cycles, flush_count
   );

   modport slave (
      input  hazard_stall, branch_flush, md_start, dmem_wait, imem_wait,
      output pc_we, ifid_we, idex_we, exmem_we,
      output ifid_flush, idex_bubble, exmem_bubble, memwb_bubble,
      output md_go, md_busy, md_result_valid, wdog_err,
      output stall_cycles, flush_count
   );
endinterface
`default_nettype wire

// File: rtl/pipe_stall_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter with synchronous clear that sticks at all-ones.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   input  logic             clear,
   output logic [WIDTH-1:0] count
);
   localparam logic [WIDTH-1:0] c_MAX = '1;
   localparam logic [WIDTH-1:0] c_ONE = WIDTH'(1);

   logic [WIDTH-1:0] r_count;

   // Clear has priority over increment; increments stop at the maximum.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count <= '0;
      end else if (clear) begin
         r_count <= '0;
      end else if (inc && (r_count != c_MAX)) begin
         r_count <= r_count + c_ONE;
      end
   end

   assign count = r_count;
endmodule
`default_nettype wire

// File: rtl/pipe_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stall_ctrl
// Description : Central stall/flush sequencer for the 5-stage pipeline.
//               Prioritises stall/flush requests, owns the mul/div occupancy
//               FSM, runs a PC-freeze watchdog and keeps perf counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stall_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int MD_LATENCY = 8,
   parameter int WDOG_LIMIT = 1024,
   parameter int CNT_W      = 16
) (
   input  logic              clk,
   input  logic              reset,
   pipe_stall_ctrl_if.slave  ctrl
);
   localparam int c_MD_CNT_W = $clog2(MD_LATENCY);
   localparam int c_WDOG_W   = $clog2(WDOG_LIMIT + 1);
   localparam logic [c_MD_CNT_W-1:0] c_MD_LOAD = c_MD_CNT_W'(MD_LATENCY - 1);
   localparam logic [c_MD_CNT_W-1:0] c_MD_ONE  = c_MD_CNT_W'(1);
   // Trip one count early so ERR is the state right after the LIMIT-th
   // frozen cycle.
   localparam logic [c_WDOG_W-1:0]   c_WDOG_TRIP = c_WDOG_W'(WDOG_LIMIT - 1);
   localparam bit c_PARAMS_OK = params_ok(MD_LATENCY, WDOG_LIMIT, CNT_W);

   generate
      if (!c_PARAMS_OK) begin : g_bad_params
         $error("pipe_stall_ctrl: illegal MD_LATENCY/WDOG_LIMIT/CNT_W");
      end
   endgenerate

   state_t                r_state;
   state_t                w_state_nxt;
   logic [c_MD_CNT_W-1:0] r_md_cnt;
   logic [c_MD_CNT_W-1:0] w_md_cnt_nxt;
   logic [c_WDOG_W-1:0]   r_wdog_cnt;

   logic w_pc_we, w_ifid_we, w_idex_we, w_exmem_we;
   logic w_ifid_flush, w_idex_bubble, w_exmem_bubble, w_memwb_bubble;
   logic w_md_go, w_md_result_valid, w_branch_taken;

   // Mealy decode of controls and next state from current state and requests.
   always_comb begin
      w_pc_we           = 1'b1;
      w_ifid_we         = 1'b1;
      w_idex_we         = 1'b1;
      w_exmem_we        = 1'b1;
      w_ifid_flush      = 1'b0;
      w_idex_bubble     = 1'b0;
      w_exmem_bubble    = 1'b0;
      w_memwb_bubble    = 1'b0;
      w_md_go           = 1'b0;
      w_md_result_valid = 1'b0;
      w_branch_taken    = 1'b0;
      w_state_nxt       = r_state;
      w_md_cnt_nxt      = r_md_cnt;

      case (r_state)
         RUN: begin
            if (ctrl.dmem_wait) begin
               w_pc_we        = 1'b0;
               w_ifid_we      = 1'b0;
               w_idex_we      = 1'b0;
               w_exmem_we     = 1'b0;
               w_memwb_bubble = 1'b1;
            end else if (ctrl.md_start) begin
               w_pc_we        = 1'b0;
               w_ifid_we      = 1'b0;
               w_idex_we      = 1'b0;
               w_exmem_bubble = 1'b1;
               w_md_go        = 1'b1;
               w_md_cnt_nxt   = c_MD_LOAD;
               w_state_nxt    = MD_EXEC;
            end else if (ctrl.hazard_stall) begin
               // Stall beats a same-cycle branch; it re-resolves next cycle.
               w_pc_we       = 1'b0;
               w_ifid_we     = 1'b0;
               w_idex_bubble = 1'b1;
            end else if (ctrl.branch_flush) begin
               // Redirect even with a fetch outstanding; that fetch is dropped.
               w_ifid_flush   = 1'b1;
               w_branch_taken = 1'b1;
            end else if (ctrl.imem_wait) begin
               w_pc_we      = 1'b0;
               w_ifid_flush = 1'b1;
            end
         end

         MD_EXEC: begin
            w_pc_we   = 1'b0;
            w_ifid_we = 1'b0;
            w_idex_we = 1'b0;
            if (r_md_cnt != '0) begin
               w_md_cnt_nxt = r_md_cnt - c_MD_ONE;
            end
            if (ctrl.dmem_wait) begin
               w_exmem_we     = 1'b0;
               w_memwb_bubble = 1'b1;
            end else if (r_md_cnt == '0) begin
               w_md_result_valid = 1'b1;
               w_state_nxt       = RUN;
            end else begin
               w_exmem_bubble = 1'b1;
            end
         end

         ERR: begin
            w_pc_we    = 1'b0;
            w_ifid_we  = 1'b0;
            w_idex_we  = 1'b0;
            w_exmem_we = 1'b0;
         end

         default: begin
            w_state_nxt = RUN;
         end
      endcase

      if ((r_state != ERR) && !w_pc_we && (r_wdog_cnt == c_WDOG_TRIP)) begin
         w_state_nxt = ERR;
      end
   end

   // State and mul/div countdown registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= RUN;
         r_md_cnt <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_md_cnt <= w_md_cnt_nxt;
      end
   end

   sat_counter #(.WIDTH(c_WDOG_W)) u_wdog_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (!w_pc_we),
      .clear (w_pc_we),
      .count (r_wdog_cnt)
   );

   sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (!w_pc_we),
      .clear (1'b0),
      .count (ctrl.stall_cycles)
   );

   sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (w_branch_taken),
      .clear (1'b0),
      .count (ctrl.flush_count)
   );

   assign ctrl.pc_we           = w_pc_we;
   assign ctrl.ifid_we         = w_ifid_we;
   assign ctrl.idex_we         = w_idex_we;
   assign ctrl.exmem_we        = w_exmem_we;
   assign ctrl.ifid_flush      = w_ifid_flush;
   assign ctrl.idex_bubble     = w_idex_bubble;
   assign ctrl.exmem_bubble    = w_exmem_bubble;
   assign ctrl.memwb_bubble    = w_memwb_bubble;
   assign ctrl.md_go           = w_md_go;
   assign ctrl.md_result_valid = w_md_result_valid;
   assign ctrl.md_busy         = (r_state == MD_EXEC);
   assign ctrl.wdog_err        = (r_state == ERR);
endmodule
`default_nettype wire

// File: tb/tb_pipe_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stall_ctrl
// Description : Directed self-checking bench for pipe_stall_ctrl
//               (MD_LATENCY=4, WDOG_LIMIT=16, CNT_W=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stall_ctrl;
   logic clk;
   logic reset;
   int   n_assert;
   int   n_fail;

   pipe_stall_ctrl_if #(.CNT_W(4)) bus ();

   pipe_stall_ctrl #(
      .MD_LATENCY (4),
      .WDOG_LIMIT (16),
      .CNT_W      (4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .ctrl  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic drive(input logic hs, input logic bf, input logic ms,
                        input logic dw, input logic iw);
      bus.hazard_stall = hs;
      bus.branch_flush = bf;
      bus.md_start     = ms;
      bus.dmem_wait    = dw;
      bus.imem_wait    = iw;
   endtask

   // Inputs change 1 ns after the rising edge; checks happen at the falling edge.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #4;
   endtask

   initial begin
      logic seen_rv;
      n_assert = 0;
      n_fail   = 0;
      reset    = 1'b1;
      drive(0, 0, 0, 0, 0);

      // ---- reset state
      #2;
      check("rst_md_busy",  bus.md_busy, 0);
      check("rst_pc_we",    bus.pc_we, 1);
      check("rst_exmem_we", bus.exmem_we, 1);
      check("rst_stall",    bus.stall_cycles, 0);
      check("rst_flush",    bus.flush_count, 0);
      check("rst_wdog_err", bus.wdog_err, 0);
      next_cycle();
      reset = 1'b0;

      // ---- mul/div, latency 4, no dmem_wait
      for (int c = 0; c <= 4; c++) begin
         drive(0, 0, 1, 0, 0);
         settle();
         check($sformatf("md_pc_we_c%0d", c),  bus.pc_we, 0);
         check($sformatf("md_go_c%0d", c),     bus.md_go, (c == 0) ? 1 : 0);
         check($sformatf("md_busy_c%0d", c),   bus.md_busy, (c == 0) ? 0 : 1);
         check($sformatf("md_exbub_c%0d", c),  bus.exmem_bubble, (c < 4) ? 1 : 0);
         check($sformatf("md_rv_c%0d", c),     bus.md_result_valid, (c == 4) ? 1 : 0);
         check($sformatf("md_exwe_c%0d", c),   bus.exmem_we, 1);
         next_cycle();
      end
      drive(0, 0, 0, 0, 0);
      settle();
      check("md_release_pc_we", bus.pc_we, 1);
      check("md_release_busy",  bus.md_busy, 0);
      check("md_stall_cnt",     bus.stall_cycles, 5);
      next_cycle();

      // ---- mul/div with dmem_wait at md_cnt=1 for 3 cycles
      drive(0, 0, 1, 0, 0);
      settle();
      check("mdw_go", bus.md_go, 1);
      next_cycle();
      for (int c = 1; c <= 6; c++) begin
         drive(0, 0, 0, (c >= 3 && c <= 5), 0);
         settle();
         check($sformatf("mdw_rv_c%0d", c),    bus.md_result_valid, (c == 6) ? 1 : 0);
         check($sformatf("mdw_mwbub_c%0d", c), bus.memwb_bubble, (c >= 3 && c <= 5) ? 1 : 0);
         check($sformatf("mdw_exwe_c%0d", c),  bus.exmem_we, (c >= 3 && c <= 5) ? 0 : 1);
         check($sformatf("mdw_busy_c%0d", c),  bus.md_busy, 1);
         next_cycle();
      end
      drive(0, 0, 0, 0, 0);
      settle();
      check("mdw_release_busy", bus.md_busy, 0);
      check("mdw_stall_cnt",    bus.stall_cycles, 12);
      next_cycle();

      // ---- reset asserted mid-MD_EXEC (md_cnt = 3)
      drive(0, 0, 1, 0, 0);
      next_cycle();
      drive(0, 0, 0, 0, 0);
      settle();
      check("mdr_busy_before", bus.md_busy, 1);
      #1;
      reset = 1'b1;
      #1;
      check("mdr_busy",    bus.md_busy, 0);
      check("mdr_pc_we",   bus.pc_we, 1);
      check("mdr_ifid_we", bus.ifid_we, 1);
      check("mdr_idex_we", bus.idex_we, 1);
      check("mdr_exmem_we", bus.exmem_we, 1);
      check("mdr_stall",   bus.stall_cycles, 0);
      check("mdr_flush",   bus.flush_count, 0);
      next_cycle();
      reset = 1'b0;
      seen_rv = 1'b0;
      for (int c = 0; c < 6; c++) begin
         settle();
         seen_rv = seen_rv | bus.md_result_valid;
         next_cycle();
      end
      check("mdr_no_rv", seen_rv, 0);
      check("mdr_idle_busy", bus.md_busy, 0);

      // ---- hazard + branch + imem in the same cycle
      drive(1, 1, 0, 0, 1);
      settle();
      check("hz_pc_we",      bus.pc_we, 0);
      check("hz_ifid_we",    bus.ifid_we, 0);
      check("hz_idex_bub",   bus.idex_bubble, 1);
      check("hz_ifid_flush", bus.ifid_flush, 0);
      next_cycle();
      drive(0, 1, 0, 0, 1);
      settle();
      check("br_flush_cnt0", bus.flush_count, 0);
      check("br_pc_we",      bus.pc_we, 1);
      check("br_ifid_flush", bus.ifid_flush, 1);
      next_cycle();
      drive(0, 0, 0, 0, 1);
      settle();
      check("br_flush_cnt1", bus.flush_count, 1);
      check("im_pc_we",      bus.pc_we, 0);
      check("im_ifid_flush", bus.ifid_flush, 1);
      next_cycle();
      drive(0, 0, 0, 0, 0);
      settle();
      check("im_flush_cnt", bus.flush_count, 1);
      check("im_stall_cnt", bus.stall_cycles, 2);
      next_cycle();

      // ---- watchdog: dmem_wait held, WDOG_LIMIT = 16
      for (int c = 0; c < 16; c++) begin
         drive(0, 0, 0, 1, 0);
         settle();
         check($sformatf("wd_err_c%0d", c),   bus.wdog_err, 0);
         check($sformatf("wd_mwbub_c%0d", c), bus.memwb_bubble, 1);
         if (c == 10) check("wd_stall_c10", bus.stall_cycles, 12);
         if (c == 14) check("wd_stall_sat", bus.stall_cycles, 15);
         next_cycle();
      end
      settle();
      check("wd_err_set",    bus.wdog_err, 1);
      check("wd_err_pc_we",  bus.pc_we, 0);
      check("wd_err_mwbub",  bus.memwb_bubble, 0);
      next_cycle();
      for (int c = 0; c < 3; c++) begin
         drive(0, 1, 1, 0, 0);
         settle();
         check($sformatf("err_sticky_c%0d", c), bus.wdog_err, 1);
         check($sformatf("err_pc_we_c%0d", c),  bus.pc_we, 0);
         check($sformatf("err_ifid_we_c%0d", c), bus.ifid_we, 0);
         check($sformatf("err_idex_we_c%0d", c), bus.idex_we, 0);
         check($sformatf("err_exmem_we_c%0d", c), bus.exmem_we, 0);
         check($sformatf("err_flush_c%0d", c),  bus.ifid_flush, 0);
         check($sformatf("err_go_c%0d", c),     bus.md_go, 0);
         check($sformatf("err_fcnt_c%0d", c),   bus.flush_count, 1);
         check($sformatf("err_stall_c%0d", c),  bus.stall_cycles, 15);
         next_cycle();
      end
      drive(0, 0, 0, 0, 0);
      #2;
      reset = 1'b1;
      #1;
      check("err_reset_clear", bus.wdog_err, 0);
      check("err_reset_pc_we", bus.pc_we, 1);
      next_cycle();
      reset = 1'b0;

      // ---- 20 branch flushes, flush_count saturates at 15
      for (int c = 0; c < 20; c++) begin
         drive(0, 1, 0, 0, 0);
         settle();
         check($sformatf("sat_fcnt_c%0d", c), bus.flush_count, (c < 15) ? c : 15);
         check($sformatf("sat_ifl_c%0d", c),  bus.ifid_flush, 1);
         next_cycle();
      end
      drive(0, 0, 0, 0, 0);
      settle();
      check("sat_fcnt_final", bus.flush_count, 15);
      check("sat_stall_zero", bus.stall_cycles, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
